// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader; packs a byte stream into 32-bit words and
//               writes them to program RAM while holding the CPU in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rw,
    output logic              bus_own,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);
    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] c_depth = 6'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           r_state;
    logic [4:0]       r_count;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_word;

    logic w_legal;
    logic w_last;

    assign w_legal = (word_count != 5'd0) && ({1'b0, word_count} <= c_depth);
    assign w_last  = (6'(r_idx) == (6'(r_count) - 6'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_word     <= '0;
            byte_ready <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rw     <= 1'b1;
            bus_own    <= 1'b0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        checksum  <= '0;
                        done      <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        if (w_legal) begin
                            r_state    <= S_RECV;
                            r_count    <= word_count;
                            r_idx      <= '0;
                            r_bcnt     <= '0;
                            err        <= 1'b0;
                            bus_own    <= 1'b1;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            err        <= 1'b1;
                            bus_own    <= 1'b0;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    // byte_ready is registered high for the whole of RECV
                    if (byte_valid) begin
                        r_word   <= {r_word[15:0], byte_data};
                        checksum <= checksum ^ byte_data;
                        if (r_bcnt == 2'd3) begin
                            r_bcnt     <= '0;
                            r_state    <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_rw     <= 1'b0;
                            mem_addr   <= ADDR_W'(r_idx);
                            mem_wdata  <= {r_word, byte_data};
                        end else begin
                            r_bcnt <= r_bcnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_rw <= 1'b1;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        bus_own   <= 1'b0;
                        cpu_rst_n <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_idx      <= r_idx + IDX_W'(1);
                        r_state    <= S_RECV;
                        byte_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Table-driven self-checking bench with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [4:0]        word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rw;
    logic              bus_own;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        checksum;

    always #5 clk = ~clk;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .bus_own    (bus_own),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         sb_q[$];
    logic [31:0] ram [DEPTH];
    bit          written [DEPTH];

    // Write monitor: every RAM strobe must match the next expected write
    always @(negedge clk) begin
        if (rst) begin
            check("bus_and_cpu_exclusive", 32'(bus_own & cpu_rst_n), 32'd0);
            if (!mem_rw) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, want no write", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                    check("wr_byte_ready_low", 32'(byte_ready), 32'd0);
                end
                if (int'(mem_addr) < DEPTH) begin
                    ram[mem_addr]     = mem_wdata;
                    written[mem_addr] = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_mem_rw",     32'(mem_rw),     32'd1);
        check("rst_bus_own",    32'(bus_own),    32'd0);
        check("rst_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_checksum",   32'(checksum),   32'd0);
    endtask

    // Drives one start + byte stream; entered and left on a falling edge
    task automatic run_load(input int wc, input int stall_at, input int stall_len,
                            input bit fixed, input int mid_start, input int abort_bytes,
                            input bit exp_err, input int exp_lat, output logic [31:0] w0);
        logic [7:0] bytes[$];
        logic [7:0] fixed_b [8];
        logic [7:0] exp_ck;
        logic [7:0] b;
        int nb, bi, stalled, cyc;
        bit finished;
        wr_t e;
        fixed_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_ck = '0; bi = 0; stalled = 0; finished = 1'b0; w0 = '0;
        nb = exp_err ? 0 : 4 * wc;
        for (int i = 0; i < nb; i++) begin
            b = fixed ? fixed_b[i % 8] : 8'($urandom_range(0, 255));
            bytes.push_back(b);
            exp_ck = exp_ck ^ b;
        end
        for (int w = 0; w < nb / 4; w++) begin
            if (abort_bytes == 0 || (w + 1) * 4 <= abort_bytes) begin
                e.addr = ADDR_W'(w);
                e.data = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
                sb_q.push_back(e);
            end
        end
        if (nb >= 4) w0 = {bytes[0], bytes[1], bytes[2], bytes[3]};

        start = 1'b1; word_count = 5'(wc); byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; word_count = 5'($urandom_range(0, 31));
        cyc = 1;
        if (exp_err) begin
            check("t1_err",       32'(err),       32'd1);
            check("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            check("t1_busy",      32'(busy),      32'd0);
        end else begin
            check("t1_byte_ready", 32'(byte_ready), 32'd1);
            check("t1_busy",       32'(busy),       32'd1);
            check("t1_bus_own",    32'(bus_own),    32'd1);
            check("t1_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
            check("t1_done",       32'(done),       32'd0);
            check("t1_err",        32'(err),        32'd0);
            check("t1_checksum",   32'(checksum),   32'd0);
        end
        while (!finished) begin
            start = 1'b0;
            if (cyc > 400) begin
                n_checks++;
                $display("FAIL load_timeout: no completion after %0d cycles, want %0d", cyc, exp_lat);
                finished = 1'b1;
            end else if (exp_err) begin
                check("err_byte_ready", 32'(byte_ready), 32'd0);
                check("err_hold",       32'(err),        32'd1);
                check("err_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
                byte_valid = 1'b1; byte_data = 8'($urandom_range(0, 255));
                if (cyc == 4) finished = 1'b1;
            end else if (abort_bytes != 0 && bi == abort_bytes) begin
                finished = 1'b1;
            end else if (done) begin
                check("done_latency",   32'(cyc),          32'(exp_lat));
                check("done_cpu_rst_n", 32'(cpu_rst_n),    32'd1);
                check("done_bus_own",   32'(bus_own),      32'd0);
                check("done_busy",      32'(busy),         32'd0);
                check("done_checksum",  32'(checksum),     32'(exp_ck));
                check("done_sb_empty",  32'(sb_q.size()),  32'd0);
                finished = 1'b1;
            end else begin
                if (cyc == mid_start) begin
                    start = 1'b1; word_count = 5'd1;
                end
                if (bi < nb && bi == stall_at && stalled < stall_len) begin
                    byte_valid = 1'b0;
                    stalled++;
                    check("stall_byte_ready", 32'(byte_ready), 32'd1);
                end else if (bi < nb) begin
                    byte_valid = 1'b1;
                    byte_data  = bytes[bi];
                    if (byte_ready) bi++;
                end else begin
                    byte_valid = 1'b0;
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        byte_valid = 1'b0;
    endtask

    typedef struct {
        int wc;
        int stall_at;
        int stall_len;
        bit fixed;
        int mid_start;
        bit exp_err;
        int exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] w0;
        vecs[0] = '{2,  0, 0, 1'b1, 0, 1'b0, 11};
        vecs[1] = '{2,  2, 3, 1'b1, 0, 1'b0, 14};
        vecs[2] = '{0,  0, 0, 1'b0, 0, 1'b1, 1};
        vecs[3] = '{17, 0, 0, 1'b0, 0, 1'b1, 1};
        vecs[4] = '{16, 0, 0, 1'b0, 0, 1'b0, 81};
        vecs[5] = '{1,  0, 0, 1'b0, 0, 1'b0, 6};
        vecs[6] = '{2,  0, 0, 1'b0, 3, 1'b0, 11};
        vecs[7] = '{3,  0, 0, 1'b0, 5, 1'b0, 16};
        vecs[8] = '{31, 0, 0, 1'b0, 0, 1'b1, 1};
        vecs[9] = '{4,  5, 2, 1'b0, 0, 1'b0, 23};
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            written[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();

        for (int v = 0; v < 10; v++) begin
            run_load(vecs[v].wc, vecs[v].stall_at, vecs[v].stall_len, vecs[v].fixed,
                     vecs[v].mid_start, 0, vecs[v].exp_err, vecs[v].exp_lat, w0);
            @(negedge clk);
        end
        check("full_load_addr15_written", 32'(written[15]), 32'd1);

        // Asynchronous reset after six bytes of a three-word load
        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
        run_load(3, 0, 0, 1'b0, 0, 6, 1'b0, 16, w0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values();
        check("abort_addr0_word", ram[0], w0);
        check("abort_addr0_written", 32'(written[0]), 32'd1);
        check("abort_addr1_untouched", 32'(written[1]), 32'd0);
        check("abort_sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("abort_cpu_held", 32'(cpu_rst_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cpu_still_held", 32'(cpu_rst_n), 32'd0);
        run_load(3, 0, 0, 1'b0, 0, 0, 1'b0, 16, w0);
        check("reload_addr0_word", ram[0], w0);
        check("reload_addr2_written", 32'(written[2]), 32'd1);
        check("reload_addr3_untouched", 32'(written[3]), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
